// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous pattern/RGB-mask scheduler for the VGA test-pattern datapath.
// Configuration from switches or an auto-cycle dwell timer is committed only at VS falling edges.
module vga_pattern_scheduler #(
  parameter int NUM_PATTERNS       = 5,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int FRAME_CNT_W        = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   vga_vs,
  input  logic [2:0]             sw_mode,
  input  logic [2:0]             sw_rgb,
  input  logic                   auto_en,
  input  logic                   key_next_n,
  output logic [2:0]             pattern_sel,
  output logic [2:0]             rgb_sel,
  output logic                   update_pulse,
  output logic                   auto_active,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // state     | meaning
  // ST_MANUAL | pattern and mask follow the switches at each frame start
  // ST_AUTO   | pattern cycles on the dwell timer or a debounced button press
  typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW_W = $clog2(FRAMES_PER_PATTERN + 1);

  state_t state, state_nx;
  logic vs_ff1, vs_ff2, vs_prev;
  logic frame_tick;
  logic key_ff1, key_ff2, key_stable, press;
  logic [DB_W-1:0] db_cnt;
  logic [2:0] auto_idx, idx_nx, next_idx, pat_nx, rgb_nx;
  logic [DW_W-1:0] dwell, dwell_nx;
  logic pending_adv, pend_nx, upd_nx;
  logic [FRAME_CNT_W-1:0] fc_nx;

  function automatic logic [2:0] norm_code(input logic [2:0] code);
    return (32'(code) >= NUM_PATTERNS) ? 3'd0 : code;
  endfunction

  assign frame_tick  = vs_prev & ~vs_ff2;
  assign auto_active = (state == ST_AUTO);
  assign next_idx    = (auto_idx == 3'(NUM_PATTERNS - 1)) ? 3'd0 : auto_idx + 3'd1;

  // Synchronisers and button debouncer; press fires only on the stable 1->0 edge
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vs_ff1     <= 1'b1;
      vs_ff2     <= 1'b1;
      vs_prev    <= 1'b1;
      key_ff1    <= 1'b1;
      key_ff2    <= 1'b1;
      key_stable <= 1'b1;
      db_cnt     <= '0;
      press      <= 1'b0;
    end else begin
      vs_ff1  <= vga_vs;
      vs_ff2  <= vs_ff1;
      vs_prev <= vs_ff2;
      key_ff1 <= key_next_n;
      key_ff2 <= key_ff1;
      press   <= 1'b0;
      if (key_ff2 == key_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_stable <= key_ff2;
        db_cnt     <= '0;
        press      <= ~key_ff2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= ST_MANUAL;
      pattern_sel  <= 3'd0;
      rgb_sel      <= 3'd0;
      update_pulse <= 1'b0;
      frame_cnt    <= '0;
      auto_idx     <= 3'd0;
      dwell        <= '0;
      pending_adv  <= 1'b0;
    end else begin
      state        <= state_nx;
      pattern_sel  <= pat_nx;
      rgb_sel      <= rgb_nx;
      update_pulse <= upd_nx;
      frame_cnt    <= fc_nx;
      auto_idx     <= idx_nx;
      dwell        <= dwell_nx;
      pending_adv  <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pat_nx   = pattern_sel;
    rgb_nx   = rgb_sel;
    idx_nx   = auto_idx;
    dwell_nx = dwell;
    pend_nx  = pending_adv;
    fc_nx    = frame_cnt;
    upd_nx   = 1'b0;
    if (frame_tick) begin
      fc_nx  = frame_cnt + 1'b1;
      rgb_nx = sw_rgb;
    end
    case (state)
      ST_MANUAL: begin
        pend_nx = 1'b0;
        if (frame_tick) begin
          if (auto_en) begin
            state_nx = ST_AUTO;
            idx_nx   = pattern_sel;
            dwell_nx = '0;
          end else begin
            pat_nx = norm_code(sw_mode);
          end
        end
      end
      ST_AUTO: begin
        pend_nx = pending_adv | press;
        if (frame_tick) begin
          if (!auto_en) begin
            state_nx = ST_MANUAL;
            pat_nx   = norm_code(sw_mode);
            pend_nx  = 1'b0;
          end else if (pending_adv || dwell == DW_W'(FRAMES_PER_PATTERN - 1)) begin
            // a press landing on this very tick is kept for the next one
            idx_nx   = next_idx;
            pat_nx   = next_idx;
            dwell_nx = '0;
            pend_nx  = press;
          end else begin
            dwell_nx = dwell + 1'b1;
            pat_nx   = auto_idx;
          end
        end
      end
      default: state_nx = ST_MANUAL;
    endcase
    if (frame_tick && (pat_nx != pattern_sel || rgb_nx != rgb_sel))
      upd_nx = 1'b1;
  end

endmodule
